groupdelay_sweep_ctrl: RTL and testbench
========================================

// Module: groupdelay_sweep_ctrl
// PURPOSE
// Sequences a uniform-step AC frequency sweep over a two-port measurement engine (S21 phase source).
// Issues one request per frequency index and collects the wrapped S21 phase.
// Unwraps the phase on the fly and emits per-point unwrapped phase plus the group-delay numerator.
// The numerator is -diff(unwrapped phase), so delay = out_gd / (2^PH_W * f_step) seconds.
// Sits between the sweep host and the shared measurement engine; a single sweep is in flight at a time.
// PARAMETERS
// NPTS   201  points per sweep (>=1)
// IDX_W  8    width of frequency index; 2^IDX_W >= NPTS
// PH_W   16   phase width; signed two's complement, full scale = 1 turn, range [-0.5,0.5) turn
// UW     25   unwrapped phase width (PH_W+IDX_W+1)
// PORTS
// clk            in   1      rising-edge clock
// rst            in   1      synchronous, active-high reset
// start          in   1      begin sweep; honoured only in IDLE
// abort          in   1      cancel sweep; honoured in any non-IDLE state
// busy           out  1      high in every state except IDLE
// done           out  1      one-cycle pulse after the last point is accepted downstream
// err_unexp      out  1      sticky: meas_rsp_valid seen outside WAIT; cleared by start or rst
// meas_req_valid out  1      request to engine; held until meas_req_ready
// meas_req_ready in   1      engine accepts the request
// meas_freq_idx  out  IDX_W  frequency index of the request, 0..NPTS-1
// meas_rsp_valid in   1      one-cycle result strobe
// meas_phase     in   PH_W   wrapped S21 phase, valid with meas_rsp_valid
// out_valid      out  1      point result valid; held until out_ready
// out_ready      in   1      downstream accepts the point
// out_idx        out  IDX_W  index of the emitted point
// out_phase_unw  out  UW     unwrapped phase, sign-extended from point 0
// out_gd         out  PH_W   group-delay numerator: -(wrapped delta), signed
// out_gd_valid   out  1      0 for idx 0 (no predecessor), 1 otherwise
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; idx=0; prev phase=0; accumulator=0.
// - FSM states: IDLE, ISSUE, WAIT, EMIT, DONE. All outputs are registered.
//   IDLE : on start, go to ISSUE next cycle with idx=0 and err_unexp cleared.
//   ISSUE: meas_req_valid=1, meas_freq_idx=idx. On meas_req_ready, go to WAIT.
//   WAIT : on meas_rsp_valid, capture and compute, then go to EMIT; out_valid=1 on the next cycle.
//   EMIT : hold out_* stable. On out_ready, go to DONE if idx==NPTS-1, else go to ISSUE with idx+1.
//   DONE : done=1 for exactly one cycle, then go to IDLE.
// - Compute at capture:
//   d = (meas_phase - prev) mod 2^PH_W, interpreted as signed; this is the unwrap.
//   idx 0: acc = sext(meas_phase), gd_valid=0, gd=0.
//   idx >0: acc += sext(d), out_gd = -d, gd_valid=1.
//   prev <= meas_phase.
//   -d for d=-2^(PH_W-1) saturates to 2^(PH_W-1)-1.
// - Minimum per-point latency with ready/ready tied high: ISSUE(1) + WAIT(>=1) + EMIT(1).
// - Precedence: rst > abort > normal transitions.
//   abort returns to IDLE next cycle; clears meas_req_valid and out_valid; no done pulse.
//   abort coinciding with start in IDLE is ignored; start wins.
// - start while busy is ignored.
// - meas_rsp_valid outside WAIT is dropped and sets err_unexp.
// - NPTS=1: one point with gd_valid=0, then DONE.
// - The accumulator never wraps within a sweep, given the UW sizing.
// TESTING
// T1 linear phase: PH_W=16, phases 0,-1024,-2048,...
//    -> out_gd=1024 for idx>=1, out_phase_unw=-1024*idx, done after NPTS points.
// T2 wrap crossing: phases 32000 then -32000
//    -> out_gd=-1536, out_phase_unw=33536 (no jump).
// T3 backpressure: out_ready low 5 cycles at idx 3
//    -> out_* stable; no meas_req_valid until accept.
// T4 abort mid-sweep: abort in WAIT at idx 7
//    -> IDLE next cycle, busy=0, no done.
//    A following start restarts at idx=0 with acc reset.
// T5 stray response: meas_rsp_valid in IDLE -> err_unexp=1, no output; next start clears it.
// T6 NPTS=1, ready held low 3 cycles
//    -> single output with gd_valid=0; done pulses one cycle after out_ready.

Source files
------------

// File: rtl/groupdelay_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : groupdelay_sweep_ctrl
// Brief    : Uniform-step AC sweep sequencer. Requests one S21 phase per
//            frequency index, unwraps it on the fly and emits the per-point
//            unwrapped phase plus the group-delay numerator -diff(phase).
// Revision : 1.0  initial release
// ============================================================================
module groupdelay_sweep_ctrl #(
    parameter int NPTS  = 201,
    parameter int IDX_W = 8,
    parameter int PH_W  = 16,
    parameter int UW    = PH_W + IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err_unexp,
    output logic             meas_req_valid,
    input  logic             meas_req_ready,
    output logic [IDX_W-1:0] meas_freq_idx,
    input  logic             meas_rsp_valid,
    input  logic [PH_W-1:0]  meas_phase,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [UW-1:0]    out_phase_unw,
    output logic [PH_W-1:0]  out_gd,
    output logic             out_gd_valid
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_issue = 3'd1;
    localparam logic [2:0] c_wait  = 3'd2;
    localparam logic [2:0] c_emit  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NPTS - 1);
    localparam logic [PH_W-1:0]  c_ph_min   = {1'b1, {(PH_W-1){1'b0}}};
    localparam logic [PH_W-1:0]  c_ph_max   = {1'b0, {(PH_W-1){1'b1}}};

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [PH_W-1:0]  r_prev;
    logic [UW-1:0]    r_acc;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_req_valid;
    logic [IDX_W-1:0] r_req_idx;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic [PH_W-1:0]  r_out_gd;
    logic             r_out_gd_valid;

    logic [PH_W-1:0]  w_delta;
    logic [PH_W-1:0]  w_neg_delta;
    logic [UW-1:0]    w_delta_sext;
    logic [UW-1:0]    w_phase_sext;

    // Modular subtraction yields the shortest signed step, i.e. the unwrap.
    always_comb begin
        w_delta      = meas_phase - r_prev;
        w_delta_sext = {{(UW-PH_W){w_delta[PH_W-1]}}, w_delta};
        w_phase_sext = {{(UW-PH_W){meas_phase[PH_W-1]}}, meas_phase};
        w_neg_delta  = (w_delta == c_ph_min) ? c_ph_max : (~w_delta + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_idle;
            r_idx          <= '0;
            r_prev         <= '0;
            r_acc          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_req_valid    <= 1'b0;
            r_req_idx      <= '0;
            r_out_valid    <= 1'b0;
            r_out_idx      <= '0;
            r_out_gd       <= '0;
            r_out_gd_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != c_idle && abort) begin
                r_state     <= c_idle;
                r_busy      <= 1'b0;
                r_req_valid <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_idle: begin
                        if (start) begin
                            r_state     <= c_issue;
                            r_idx       <= '0;
                            r_err       <= 1'b0;
                            r_busy      <= 1'b1;
                            r_req_valid <= 1'b1;
                            r_req_idx   <= '0;
                        end
                    end
                    c_issue: begin
                        if (meas_req_ready) begin
                            r_state     <= c_wait;
                            r_req_valid <= 1'b0;
                        end
                    end
                    c_wait: begin
                        if (meas_rsp_valid) begin
                            r_state     <= c_emit;
                            r_out_valid <= 1'b1;
                            r_out_idx   <= r_idx;
                            r_prev      <= meas_phase;
                            if (r_idx == '0) begin
                                r_acc          <= w_phase_sext;
                                r_out_gd       <= '0;
                                r_out_gd_valid <= 1'b0;
                            end else begin
                                r_acc          <= r_acc + w_delta_sext;
                                r_out_gd       <= w_neg_delta;
                                r_out_gd_valid <= 1'b1;
                            end
                        end
                    end
                    c_emit: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            if (r_idx == c_last_idx) begin
                                r_state <= c_done;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= c_issue;
                                r_idx       <= r_idx + 1'b1;
                                r_req_valid <= 1'b1;
                                r_req_idx   <= r_idx + 1'b1;
                            end
                        end
                    end
                    c_done: begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= c_idle;
                        r_busy      <= 1'b0;
                        r_req_valid <= 1'b0;
                        r_out_valid <= 1'b0;
                    end
                endcase
            end
            // A response nobody asked for is dropped but flagged; this beats the start clear.
            if (meas_rsp_valid && r_state != c_wait) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err_unexp      = r_err;
    assign meas_req_valid = r_req_valid;
    assign meas_freq_idx  = r_req_idx;
    assign out_valid      = r_out_valid;
    assign out_idx        = r_out_idx;
    assign out_phase_unw  = r_acc;
    assign out_gd         = r_out_gd;
    assign out_gd_valid   = r_out_gd_valid;

endmodule
`default_nettype wire

// File: tb/tb_groupdelay_sweep_ctrl.sv
`default_nettype none
// Testbench for groupdelay_sweep_ctrl: randomized engine and sink models feed a
// scoreboard whose expected points come from a plain-arithmetic unwrap model.
module tb_groupdelay_sweep_ctrl;
    localparam int NPTS  = 201;
    localparam int IDX_W = 8;
    localparam int PH_W  = 16;
    localparam int UW    = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, abort;
    logic             busy, done, err_unexp;
    logic             meas_req_valid, meas_req_ready;
    logic [IDX_W-1:0] meas_freq_idx;
    logic             meas_rsp_valid;
    logic [PH_W-1:0]  meas_phase;
    logic             out_valid, out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [UW-1:0]    out_phase_unw;
    logic [PH_W-1:0]  out_gd;
    logic             out_gd_valid;

    // single-point instance
    logic        s_start, s_abort, s_busy, s_done, s_err;
    logic        s_req_v, s_req_r, s_rsp_v, s_out_v, s_out_r, s_gdv;
    logic [0:0]  s_fidx, s_out_idx;
    logic [15:0] s_phase, s_gd;
    logic [17:0] s_unw;

    groupdelay_sweep_ctrl #(.NPTS(NPTS), .IDX_W(IDX_W), .PH_W(PH_W), .UW(UW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .err_unexp(err_unexp), .meas_req_valid(meas_req_valid), .meas_req_ready(meas_req_ready),
        .meas_freq_idx(meas_freq_idx), .meas_rsp_valid(meas_rsp_valid), .meas_phase(meas_phase),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_phase_unw(out_phase_unw), .out_gd(out_gd), .out_gd_valid(out_gd_valid));

    groupdelay_sweep_ctrl #(.NPTS(1), .IDX_W(1), .PH_W(16), .UW(18)) u_dut1 (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .busy(s_busy), .done(s_done),
        .err_unexp(s_err), .meas_req_valid(s_req_v), .meas_req_ready(s_req_r),
        .meas_freq_idx(s_fidx), .meas_rsp_valid(s_rsp_v), .meas_phase(s_phase),
        .out_valid(s_out_v), .out_ready(s_out_r), .out_idx(s_out_idx),
        .out_phase_unw(s_unw), .out_gd(s_gd), .out_gd_valid(s_gdv));

    typedef struct {
        int     idx;
        longint unw;
        int     gd;
        bit     gdv;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ph[NPTS];
    int   lat_min = 1, lat_max = 1;
    bit   rnd_ready = 1'b0;
    int   stray_req = 0;
    int   sink_mode = 0;
    int   hold_idx = 3;
    int   n_out = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap_ph(input int v);
        int m;
        m = v & 32'hFFFF;
        return (m >= 32768) ? m - 65536 : m;
    endfunction

    // Unwrapped phase = first sample plus the sum of shortest steps.
    function automatic exp_t model(input int k);
        exp_t e;
        int   d;
        e.idx = k;
        e.unw = ph[0];
        d = 0;
        for (int j = 1; j <= k; j++) begin
            d = wrap_ph(ph[j] - ph[j-1]);
            e.unw += d;
        end
        e.gdv = (k != 0);
        e.gd  = (k == 0) ? 0 : ((-d > 32767) ? 32767 : -d);
        return e;
    endfunction

    initial begin : engine
        int pend = 0, pidx = 0, hidx = 0, req_cnt = 0, stray_done = 0;
        bit hs, kill;
        meas_req_ready = 1'b0;
        meas_rsp_valid = 1'b0;
        meas_phase     = '0;
        forever begin
            @(negedge clk);
            hs   = meas_req_valid && meas_req_ready;
            hidx = int'(meas_freq_idx);
            kill = abort && busy;
            if (start && !busy) req_cnt = 0;
            if (hs) begin
                chk("req_idx", hidx, req_cnt);
                req_cnt++;
            end
            @(posedge clk); #1;
            meas_rsp_valid = 1'b0;
            if (kill) pend = 0;
            if (hs && !kill) begin
                pend = lat_min + $urandom_range(0, lat_max - lat_min);
                pidx = hidx;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    meas_rsp_valid = 1'b1;
                    meas_phase     = PH_W'(ph[pidx]);
                    sb.push_back(model(pidx));
                end
            end else if (stray_req != stray_done) begin
                stray_done     = stray_req;
                meas_rsp_valid = 1'b1;
                meas_phase     = PH_W'($urandom);
            end
            meas_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : sink
        int low_left = 0;
        bit used = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (sink_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!used && out_valid && int'(out_idx) == hold_idx) begin
                        used = 1'b1;
                        low_left = 5;
                    end
                    if (low_left > 0) begin
                        out_ready = 1'b0;
                        low_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        bit   hold_v = 1'b0;
        logic [IDX_W-1:0] h_idx = '0;
        logic [UW-1:0]    h_unw = '0;
        logic [PH_W-1:0]  h_gd = '0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (done) done_cnt++;
            if (out_valid) begin
                chk("no_req_during_out", meas_req_valid, 0);
                if (hold_v) begin
                    chk("stable_idx", out_idx, h_idx);
                    chk("stable_unw", out_phase_unw, h_unw);
                    chk("stable_gd", out_gd, h_gd);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: idx %0d with nothing expected", out_idx);
                    end else begin
                        e = sb.pop_front();
                        chk("out_idx", out_idx, e.idx);
                        chk("out_phase_unw", longint'($signed(out_phase_unw)), e.unw);
                        chk("out_gd", int'($signed(out_gd)), e.gd);
                        chk("out_gd_valid", out_gd_valid, e.gdv);
                        n_out++;
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    h_idx = out_idx; h_unw = out_phase_unw; h_gd = out_gd;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int d0, input int budget);
        int c;
        c = 0;
        while (c < budget && done_cnt == d0) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL sweep_timeout: done not seen within %0d cycles", budget);
        end
        @(negedge clk);
        chk("done_once", done_cnt, d0 + 1);
        chk("busy_after_done", busy, 0);
        chk("points_emitted", n_out - n0, NPTS);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NPTS; k++) ph[k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic full_sweep();
        int n0, d0;
        n0 = n_out; d0 = done_cnt;
        pulse_start();
        wait_done(n0, d0, 20000);
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0, d0, c;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        s_start = 1'b0; s_abort = 1'b0; s_req_r = 1'b0; s_rsp_v = 1'b0;
        s_phase = '0; s_out_r = 1'b0;
        for (int k = 0; k < NPTS; k++) ph[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_unexp, 0);
        chk("rst_req_valid", meas_req_valid, 0);
        chk("rst_freq_idx", meas_freq_idx, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_unw", out_phase_unw, 0);
        chk("rst_out_gd", out_gd, 0);
        chk("rst_gd_valid", out_gd_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        // linear phase, everything tied ready
        for (int k = 0; k < NPTS; k++) ph[k] = wrap_ph(-1024 * k);
        full_sweep();

        // wrap crossing, saturating step, random handshakes, ignored restart
        fill_random();
        ph[0] = 32000; ph[1] = -32000; ph[2] = wrap_ph(-32000 - 32768);
        lat_min = 1; lat_max = 4; rnd_ready = 1'b1; sink_mode = 1;
        n0 = n_out; d0 = done_cnt;
        pulse_start();
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(n0, d0, 20000);

        // backpressure at idx 3
        fill_random();
        lat_max = 3; sink_mode = 2; hold_idx = 3;
        full_sweep();

        // abort while waiting on idx 7, then clean restart
        fill_random();
        lat_min = 8; lat_max = 8; rnd_ready = 1'b0; sink_mode = 0;
        n0 = n_out; d0 = done_cnt;
        pulse_start();
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(meas_req_valid && meas_req_ready && meas_freq_idx == 8'd7) && c < 2000);
        chk("abort_reached_idx7", meas_freq_idx, 7);
        @(posedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_req_valid", meas_req_valid, 0);
        chk("abort_points", n_out - n0, 7);
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_err", err_unexp, 0);
        fill_random();
        lat_min = 1; lat_max = 2;
        full_sweep();

        // stray response in IDLE, then start+abort together
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_err", err_unexp, 1);
        chk("stray_no_out", out_valid, 0);
        chk("stray_busy", busy, 0);
        fill_random();
        lat_max = 1;
        n0 = n_out; d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_clears_err", err_unexp, 0);
        chk("start_beats_abort", busy, 1);
        wait_done(n0, d0, 20000);

        // single-point sweep with output held off
        s_req_r = 1'b1;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!s_req_v && c < 50);
        chk("n1_req_valid", s_req_v, 1);
        chk("n1_req_idx", s_fidx, 0);
        @(posedge clk); #1 s_rsp_v = 1'b1; s_phase = 16'(-12345);
        @(posedge clk); #1 s_rsp_v = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("n1_out_valid", s_out_v, 1);
            chk("n1_out_idx", s_out_idx, 0);
            chk("n1_unw", longint'($signed(s_unw)), -12345);
            chk("n1_gd", s_gd, 0);
            chk("n1_gd_valid", s_gdv, 0);
            chk("n1_no_done_yet", s_done, 0);
        end
        @(posedge clk); #1 s_out_r = 1'b1;
        @(posedge clk); #1 s_out_r = 1'b0;
        @(negedge clk);
        chk("n1_done_pulse", s_done, 1);
        chk("n1_out_dropped", s_out_v, 0);
        @(negedge clk);
        chk("n1_done_cleared", s_done, 0);
        chk("n1_idle", s_busy, 0);
        chk("n1_err", s_err, 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
